// File: rtl/bin_to_bcd_seq_if.sv
// bin_to_bcd_seq_if: start/done handshake and data bus of the binary-to-BCD converter
interface bin_to_bcd_seq_if #(
   parameter int N_BITS = 16,
   parameter int N_DIGITS = 4
);
   logic                  i_start;
   logic [N_BITS-1:0]     i_bin;
   logic [4*N_DIGITS-1:0] o_bcd;
   logic                  o_ovf;
   logic                  o_busy;
   logic                  o_done;
   modport master (output i_start, i_bin, input o_bcd, o_ovf, o_busy, o_done);
   modport slave (input i_start, i_bin, output o_bcd, o_ovf, o_busy, o_done);
endinterface

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble converter, one add-3/shift iteration per clock
module bin_to_bcd_seq #(
   parameter int N_BITS = 16,
   parameter int N_DIGITS = 4
) (
   input logic             i_clk,
   input logic             i_rst_n,
   bin_to_bcd_seq_if.slave bus
);
   localparam int CW = $clog2(N_BITS + 1);
   localparam int BW = 4 * N_DIGITS;
   typedef enum logic {IDLE, CONV} state_t;
   state_t            state_q, state_d;
   logic [N_BITS-1:0] shift_q, shift_d;
   logic [BW-1:0]     scratch_q, scratch_d, adj, bcd_q, bcd_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              sticky_q, sticky_d, sticky_n;
   logic              ovf_q, ovf_d, done_q, done_d;
   genvar g;
   for (g = 0; g < N_DIGITS; g++) begin : g_add3
      assign adj[4*g +: 4] = scratch_q[4*g +: 4] >= 4'd5 ? scratch_q[4*g +: 4] + 4'd3 : scratch_q[4*g +: 4];
   end
   // a 1 leaving the top digit means the running value reached 10^N_DIGITS
   assign sticky_n = sticky_q | adj[BW-1];
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      scratch_d = scratch_q;
      cnt_d     = cnt_q;
      sticky_d  = sticky_q;
      bcd_d     = bcd_q;
      ovf_d     = ovf_q;
      done_d    = 1'b0;
      if (state_q == IDLE) begin
         if (bus.i_start) begin
            state_d   = CONV;
            shift_d   = bus.i_bin;
            scratch_d = '0;
            sticky_d  = 1'b0;
            cnt_d     = CW'(N_BITS);
         end
      end else begin
         shift_d   = shift_q << 1;
         scratch_d = {adj[BW-2:0], shift_q[N_BITS-1]};
         sticky_d  = sticky_n;
         cnt_d     = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            ovf_d   = sticky_n;
            bcd_d   = sticky_n ? {N_DIGITS{4'h9}} : scratch_d;
         end
      end
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         scratch_q <= '0;
         cnt_q     <= '0;
         sticky_q  <= 1'b0;
         bcd_q     <= '0;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         scratch_q <= scratch_d;
         cnt_q     <= cnt_d;
         sticky_q  <= sticky_d;
         bcd_q     <= bcd_d;
         ovf_q     <= ovf_d;
         done_q    <= done_d;
      end
   end
   assign bus.o_bcd  = bcd_q;
   assign bus.o_ovf  = ovf_q;
   assign bus.o_busy = state_q == CONV;
   assign bus.o_done = done_q;
endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential double-dabble converter that turns the binary occupancy count from `countreg` into packed BCD digits for the per-digit `hex_to_sseg` decoders, so the seven-segment display shows decimal instead of hex. It uses one add-3/shift iteration per clock. A start/done handshake controls each conversion, and the last result is held on the output between conversions. The top level pulses `i_start` periodically, or whenever the count changes, and drives the display from `o_bcd`.

## Interface
- `N_BITS`, default 16: width of the binary input; legal range 1..32.
- `N_DIGITS`, default 4: number of BCD digits produced; legal range 1..8.
- `i_clk`  in  1: system clock; all state changes on its rising edge.
- `i_rst_n`  in  1: reset, asynchronous and active-low.
- `i_start`  in  1: conversion request, sampled on rising edge; honoured only when idle.
- `i_bin`  in  N_BITS: unsigned binary value; captured on the accepted-start edge.
- `o_bcd`  out  4*N_DIGITS: packed BCD result, digit 0 (ones) in [3:0]; registered and held.
- `o_ovf`  out  1: last result did not fit in N_DIGITS digits; registered and held with `o_bcd`.
- `o_busy`  out  1: conversion in progress.
- `o_done`  out  1: one-cycle pulse when `o_bcd`/`o_ovf` update.

## Operation
- FSM states are IDLE and CONV.
- IDLE: `o_busy`=0.
  - If `i_start`=1 at an edge: capture `i_bin` into the shift register, clear the BCD scratch (4*N_DIGITS bits) and the sticky overflow, load the iteration counter with N_BITS, and go to CONV.
- CONV: `o_busy`=1. Each edge performs one iteration:
  - For every scratch digit ≥5, add 3 to it (all digits in parallel, using the pre-shift values).
  - Shift {scratch, shift_reg} left by one bit.
  - If the bit shifted out of the top scratch digit is 1, set the sticky overflow.
  - Decrement the counter.
- On the edge that performs iteration N_BITS:
  - If sticky overflow is clear (including the final shift-out): load `o_bcd` from the post-shift scratch and set `o_ovf`=0.
  - Otherwise: saturate `o_bcd` to all digits 9 and set `o_ovf`=1.
  - Set `o_done`=1 and return to IDLE.
- `o_done` is high for exactly one cycle and low in every other cycle.
- `o_bcd` and `o_ovf` change only on that result-load edge.
- `i_start` during CONV is ignored. It is not queued and causes no error.
- Changes to `i_bin` after the accepted-start edge do not affect the current result.
- `i_start` held high continuously gives back-to-back conversions: each `o_done` cycle is an IDLE cycle, so the start is re-accepted there.
- Arithmetic is unsigned, with no sign handling.
  - Overflow is exact: `o_ovf`=1 if and only if the captured value ≥ 10^N_DIGITS.
  - With N_BITS=16 and N_DIGITS=5, `o_ovf` is always 0.

## Timing
- Reset, asserted asynchronously at any time including mid-conversion:
  - Outputs: `o_bcd`=0, `o_ovf`=0, `o_busy`=0, `o_done`=0.
  - FSM goes to IDLE; counter, scratch and sticky flag are cleared.
  - No partial result ever reaches `o_bcd`.
- After reset deasserts, the first rising edge may accept `i_start`.
- Latency, with start sampled at edge E0:
  - `o_busy`=1 from after E0 until after edge E0+N_BITS.
  - `o_done`=1 and the new `o_bcd` are visible in the cycle after edge E0+N_BITS.
  - Start-to-done is N_BITS+1 clock edges, which is 17 at defaults.
- Throughput is one conversion per N_BITS+1 cycles when `i_start` is held high.
- `o_done` and `o_busy` are never high in the same cycle.
- Every output comes directly from a register, with no combinational path from any input to any output.

## Test plan
- Reset: assert `i_rst_n`=0 mid-conversion (after 5 iterations) -> all outputs 0 immediately, without waiting for a clock edge. After release with no start: no `o_done`, and `o_bcd` stays 0x0000.
- Defaults (N_BITS=16, N_DIGITS=4), `i_bin`=0x04D2 (1234) with a one-cycle start -> `o_busy` high for 16 cycles, then `o_done` 17 edges after start, `o_bcd`=0x1234, `o_ovf`=0.
- Boundary values:
  - 0 -> `o_bcd`=0x0000, `o_ovf`=0.
  - 9999 -> 0x9999, `o_ovf`=0.
  - 10000 -> 0x9999, `o_ovf`=1.
  - 65535 -> 0x9999, `o_ovf`=1.
- Start while busy, `i_bin` changed mid-conversion:
  - Start with 42; at cycle 3 pulse start with `i_bin`=77 -> a single `o_done`, `o_bcd`=0x0042.
  - A later start with 77 -> 0x0077.
- Back-to-back: hold `i_start`=1 while `i_bin` steps 1,2,3 in step with each accepted start -> `o_done` every 17 cycles with results 0x0001, 0x0002, 0x0003, and `o_busy` low exactly in the `o_done` cycles.
- Parameter variant N_DIGITS=5, random sweep of 1000 values -> `o_bcd` matches a reference decimal model and `o_ovf` is never set.
